// File: rtl/psl_source_pkg.sv
// Shared encodings for the PSL write-buffer source selector.
package psl_source_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Source channel indices
  localparam int SRC_PSL  = 0;
  localparam int SRC_DDR3 = 1;

  // Mode codes the parent decodes into sel
  localparam logic [2:0] MODE_PROGRAM       = 3'b000;
  localparam logic [2:0] MODE_SOLID_ISLANDS = 3'b001;
  localparam logic [2:0] MODE_CORRECTION    = 3'b010;
  localparam logic [2:0] MODE_DDR3_INIT     = 3'b100;
  localparam logic [2:0] MODE_DDR3_READ     = 3'b101;
  localparam logic [2:0] MODE_DDR3_WRITE    = 3'b110;

endpackage

// File: rtl/psl_skid_fifo2.sv
// Two-entry skid FIFO; the head entry is the registered output.
module psl_skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] head, tail;

  assign dout = head;

  // Head/tail shuffle; the caller never pushes when full or pops when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) head <= din;
          else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/psl_source_mux.sv
// Back-pressured source selector feeding the PSL write buffer. A source
// change drains the skid FIFO before handover so streams never interleave.
module psl_source_mux
  import psl_source_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 1,
  parameter int DATA_W  = 2048,
  parameter int ITEM_W  = 6,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*ITEM_W-1:0] src_items,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ITEM_W-1:0]         out_items,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      switching,
  output logic                      sel_err,
  output logic [CNT_W-1:0]          beat_count
);

  // Slot table spans the full select range so any active_sel indexes cleanly;
  // slots past NUM_SRC read as idle.
  localparam int NSLOT = 1 << SEL_W;
  localparam logic [SEL_W:0] NSRC_L = (SEL_W+1)'(NUM_SRC);

  logic [NSLOT-1:0][DATA_W-1:0] d_arr;
  logic [NSLOT-1:0][ITEM_W-1:0] i_arr;
  logic [NSLOT-1:0]             v_arr;

  state_t     state;
  logic [1:0] fcnt;
  logic       run, full, push, pop, sel_oor;

  genvar g;
  generate
    for (g = 0; g < NSLOT; g++) begin : g_slot
      if (g < NUM_SRC) begin : g_src
        assign d_arr[g] = src_data[g*DATA_W +: DATA_W];
        assign i_arr[g] = src_items[g*ITEM_W +: ITEM_W];
        assign v_arr[g] = src_valid[g];
      end else begin : g_idle
        assign d_arr[g] = '0;
        assign i_arr[g] = '0;
        assign v_arr[g] = 1'b0;
      end
    end
    for (g = 0; g < NUM_SRC; g++) begin : g_rdy
      assign src_ready[g] = ~rst & run & ~full & (active_sel == SEL_W'(g));
    end
  endgenerate

  assign run       = (state == ST_RUN);
  assign full      = (fcnt == 2'd2);
  assign sel_oor   = ({1'b0, sel} >= NSRC_L);
  assign push      = run & ~full & v_arr[active_sel];
  assign out_valid = (fcnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign switching = (state == ST_DRAIN);

  psl_skid_fifo2 #(.W(DATA_W + ITEM_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({i_arr[active_sel], d_arr[active_sel]}),
    .pop   (pop),
    .dout  ({out_items, out_data}),
    .count (fcnt)
  );

  // RUN/DRAIN control: leave RUN on any sel mismatch, hand over once empty
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      active_sel <= '0;
      sel_err    <= 1'b0;
    end else begin
      if (sel_oor) sel_err <= 1'b1;
      case (state)
        ST_RUN: if (sel != active_sel) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (fcnt == 2'd0) begin
            if (!sel_oor) active_sel <= sel;
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Output handshake counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)      beat_count <= '0;
    else if (pop) beat_count <= beat_count + 1'b1;
  end

endmodule

// File: tb/tb_psl_source_mux.sv
// Directed bench for psl_source_mux: streaming, backpressure, switching,
// bad select, reset mid-stream and counter wrap.
module tb_psl_source_mux;

  localparam int NUM_SRC = 2;
  localparam int SEL_W   = 2;
  localparam int DATA_W  = 16;
  localparam int ITEM_W  = 6;
  localparam int CNT_W   = 4;

  logic                      clk;
  logic                      rst;
  logic [SEL_W-1:0]          sel;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC*ITEM_W-1:0] src_items;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [DATA_W-1:0]         out_data;
  logic [ITEM_W-1:0]         out_items;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          active_sel;
  logic                      switching;
  logic                      sel_err;
  logic [CNT_W-1:0]          beat_count;

  int n_cmp = 0;
  int n_err = 0;

  psl_source_mux #(
    .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DATA_W(DATA_W),
    .ITEM_W(ITEM_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel),
    .src_data(src_data), .src_items(src_items), .src_valid(src_valid),
    .src_ready(src_ready),
    .out_data(out_data), .out_items(out_items), .out_valid(out_valid),
    .out_ready(out_ready),
    .active_sel(active_sel), .switching(switching), .sel_err(sel_err),
    .beat_count(beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [DATA_W-1:0] d);
    src_valid[0]       = v;
    src_data[15:0]     = d;
  endtask

  task automatic drv1(input logic v, input logic [DATA_W-1:0] d);
    src_valid[1]       = v;
    src_data[31:16]    = d;
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 2'd0;
    src_data  = '0;
    src_items = {6'd7, 6'd4};
    src_valid = '0;
    out_ready = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_ready",  32'(src_ready),  0);
    chk("rst_valid",  32'(out_valid),  0);
    chk("rst_data",   32'(out_data),   0);
    chk("rst_items",  32'(out_items),  0);
    chk("rst_asel",   32'(active_sel), 0);
    chk("rst_sw",     32'(switching),  0);
    chk("rst_err",    32'(sel_err),    0);
    chk("rst_cnt",    32'(beat_count), 0);
    rst = 1'b0;
    tick();
    chk("run_ready", 32'(src_ready), 32'b01);

    // Streaming D0..D3 with 1-cycle latency
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drv0(1'b1, 16'hA000 + 16'(k));
      tick();
      chk("strm_data",  32'(out_data),  32'hA000 + k);
      chk("strm_items", 32'(out_items), 4);
      chk("strm_vld",   32'(out_valid), 1);
      chk("strm_rdy",   32'(src_ready), 32'b01);
    end
    drv0(1'b0, 16'h0);
    tick();
    chk("strm_empty", 32'(out_valid),  0);
    chk("strm_cnt",   32'(beat_count), 4);

    // Backpressure: two accepted, then ready drops
    out_ready = 1'b0;
    drv0(1'b1, 16'hB000);
    tick();
    chk("bp_d0",   32'(out_data),  32'hB000);
    chk("bp_rdy1", 32'(src_ready), 32'b01);
    drv0(1'b1, 16'hB001);
    tick();
    chk("bp_rdy2", 32'(src_ready), 0);
    drv0(1'b1, 16'hB002);
    tick();
    chk("bp_hold_rdy",  32'(src_ready),  0);
    chk("bp_hold_data", 32'(out_data),   32'hB000);
    chk("bp_hold_cnt",  32'(beat_count), 4);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1", 32'(out_data),  32'hB001);
    chk("bp_rrdy", 32'(src_ready), 32'b01);
    tick();
    chk("bp_pop2", 32'(out_data),  32'hB002);
    chk("bp_v2",   32'(out_valid), 1);
    drv0(1'b0, 16'h0);
    tick();
    chk("bp_empty", 32'(out_valid),  0);
    chk("bp_cnt",   32'(beat_count), 7);

    // Switch 0 -> 1 with two beats buffered
    out_ready = 1'b0;
    drv0(1'b1, 16'hC000);
    tick();
    drv0(1'b1, 16'hC001);
    tick();
    drv0(1'b0, 16'h0);
    drv1(1'b1, 16'hD000);
    sel = 2'd1;
    tick();
    chk("sw_flag", 32'(switching),  1);
    chk("sw_rdy",  32'(src_ready),  0);
    chk("sw_asel", 32'(active_sel), 0);
    chk("sw_head", 32'(out_data),   32'hC000);
    out_ready = 1'b1;
    tick();
    chk("sw_pop1", 32'(out_data),   32'hC001);
    chk("sw_asl1", 32'(active_sel), 0);
    tick();
    chk("sw_empty", 32'(out_valid),  0);
    chk("sw_flag2", 32'(switching),  1);
    chk("sw_asl2",  32'(active_sel), 0);
    tick();
    chk("sw_asel_new", 32'(active_sel), 1);
    chk("sw_done",     32'(switching),  0);
    chk("sw_rdy_new",  32'(src_ready),  32'b10);
    tick();
    chk("sw_d1_data",  32'(out_data),  32'hD000);
    chk("sw_d1_items", 32'(out_items), 7);
    drv1(1'b0, 16'h0);
    tick();
    chk("sw_cnt", 32'(beat_count), 10);

    // Back to source 0 with an empty FIFO: two-cycle gap
    sel = 2'd0;
    tick();
    chk("gap_sw", 32'(switching), 1);
    tick();
    chk("gap_asel", 32'(active_sel), 0);
    chk("gap_rdy",  32'(src_ready),  32'b01);

    // Out-of-range select
    sel = 2'd3;
    tick();
    chk("oor_err",  32'(sel_err),    1);
    chk("oor_sw",   32'(switching),  1);
    tick();
    chk("oor_asel", 32'(active_sel), 0);
    sel = 2'd0;
    tick();
    chk("oor_run",  32'(switching), 0);
    chk("oor_rdy",  32'(src_ready), 32'b01);
    drv0(1'b1, 16'hE000);
    tick();
    chk("oor_data", 32'(out_data), 32'hE000);
    drv0(1'b0, 16'h0);
    tick();
    chk("oor_sticky", 32'(sel_err),    1);
    chk("oor_cnt",    32'(beat_count), 11);

    // Reset with two beats buffered
    out_ready = 1'b0;
    drv0(1'b1, 16'hF000);
    tick();
    drv0(1'b1, 16'hF001);
    tick();
    chk("rm_full", 32'(out_valid), 1);
    drv0(1'b0, 16'h0);
    rst = 1'b1;
    tick();
    chk("rm_rdy_in_rst", 32'(src_ready), 0);
    rst = 1'b0;
    tick();
    chk("rm_vld",  32'(out_valid),  0);
    chk("rm_cnt",  32'(beat_count), 0);
    chk("rm_asel", 32'(active_sel), 0);
    chk("rm_err",  32'(sel_err),    0);
    chk("rm_rdy",  32'(src_ready),  32'b01);

    // 17 pops wrap a 4-bit counter to 1
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drv0(1'b1, 16'h5000 + 16'(k));
      tick();
      chk("wrap_data", 32'(out_data), 32'h5000 + k);
    end
    drv0(1'b0, 16'h0);
    tick();
    chk("wrap_cnt", 32'(beat_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psl_source_mux.md
# psl_source_mux

Parametrised, back-pressured source selector feeding the PSL write buffer. It merges NUM_SRC producer streams into one registered stream, for example the correction units' result path and the DDR3-to-buffer formatter. Each beat carries its items-per-data sideband, held in a 2-entry skid FIFO. Source changes are switched glitch-free: the block drains before handing over, so beats from two sources never interleave. It sits between the producers and the pslBuffer data/num_items_per_data inputs, replacing the unconditional mode-based flop stage, which has no backpressure.

## Interface
- NUM_SRC, 2, number of producer channels (≥2)
- SEL_W, 1, select width; 2^SEL_W ≥ NUM_SRC
- DATA_W, 2048, beat data width
- ITEM_W, 6, items-per-data sideband width
- CNT_W, 32, beat counter width

Reset is synchronous and active-high.

- clk  in  1  PSL clock (ha_pclock domain); all logic on rising edge
- rst  in  1  synchronous reset, active-high
- sel  in  SEL_W  requested source index, sampled every cycle
- src_data  in  NUM_SRC*DATA_W  per-source beat; source i at [i*DATA_W +: DATA_W]
- src_items  in  NUM_SRC*ITEM_W  per-source items-per-data, same packing
- src_valid  in  NUM_SRC  per-source beat valid
- src_ready  out  NUM_SRC  per-source ready; at most one bit high
- out_data  out  DATA_W  head beat
- out_items  out  ITEM_W  head beat sideband
- out_valid  out  1  head beat valid
- out_ready  in  1  consumer accepts head
- active_sel  out  SEL_W  source currently routed
- switching  out  1  high while in DRAIN
- sel_err  out  1  sticky: out-of-range sel seen
- beat_count  out  CNT_W  output handshakes since reset

## Operation
- FSM states: RUN and DRAIN; reset state is RUN.
- RUN:
  - src_ready[active_sel] = (fifo_count<2); all other ready bits are 0.
  - A push occurs on src_valid[active_sel] & src_ready[active_sel]; data and items are written together.
  - Next state is DRAIN if sel≠active_sel, including an out-of-range sel.
- DRAIN:
  - All src_ready bits are 0.
  - FIFO pops continue.
  - When fifo_count==0:
    - active_sel is set to sel if sel<NUM_SRC; otherwise active_sel holds and sel_err sets.
    - State returns to RUN.
- Out-of-range sel seen in RUN or DRAIN sets sel_err; only rst clears it.
- Skid FIFO: 2 entries, registered outputs, out_valid = (fifo_count>0).
  - Pop on out_valid & out_ready.
  - A simultaneous push and pop holds the count.
  - Push with count==2 cannot occur, since ready is low.
- beat_count increments by 1 per pop and wraps modulo 2^CNT_W.
- Reset values: src_ready 0 (forced 0 while rst high), out_valid 0, out_data 0, out_items 0, active_sel 0, switching 0, sel_err 0, beat_count 0, fifo_count 0.

## Timing
- Latency: beat accepted in cycle N appears on out_* in cycle N+1 when the FIFO was empty. Otherwise it appears after the beats ahead of it.
- Throughput: 1 beat/cycle sustained while out_ready=1 and the source is valid.
- Backpressure: with out_ready=0, two beats are accepted, then src_ready drops the cycle after the second push. src_ready rises the cycle after the first pop.
- sel change in cycle N:
  - A push in cycle N is still accepted.
  - switching=1 and ready=0 from cycle N+1.
- Switch time: handover occurs in the cycle fifo_count reaches 0. The new source's ready rises the following cycle. Minimum gap is 2 cycles with an empty FIFO.
- Reversion: if sel returns to active_sel during DRAIN, the drain still completes and active_sel is unchanged.
- Reset mid-operation: FIFO contents are discarded with no output, and state returns to RUN on source 0 the cycle after rst falls.

## Structure
- Package psl_source_pkg holds:
  - state encoding (ST_RUN, ST_DRAIN);
  - source indices SRC_PSL=0, SRC_DDR3=1;
  - mode codes CORRECTION 'b010, SOLID_ISLANDS 'b001, PROGRAM 'b000, DDR3_INIT 'b100, DDR3_READ 'b101, DDR3_WRITE 'b110, used by the parent to derive sel.
- One sub-module, psl_skid_fifo2: a 2-entry registered FIFO of width DATA_W+ITEM_W with push/pop/count.
- The parent instantiates the mux, FSM and counter around it.

## Test plan
- Reset, sel=0:
  - Source 0 sends beats D0..D3 (items 4) with out_ready=1.
  - Required: out_* shows D0..D3 on consecutive cycles, 1-cycle latency; beat_count=4; src_ready[1]=0 throughout.
- out_ready=0 and source 0 valid continuously:
  - Required: exactly 2 beats accepted, src_ready[0]=0 after them.
  - After out_ready=1: order preserved, no beat lost or duplicated.
- sel 0→1 with 2 beats buffered:
  - Required: switching=1 the next cycle; both source-0 beats emerge; active_sel=1 only after the FIFO is empty; first source-1 beat follows them.
- sel=3 with NUM_SRC=2:
  - Required: sel_err=1, active_sel stays 0.
  - sel back to 0: traffic resumes and sel_err stays 1.
- rst asserted with 2 beats in the FIFO:
  - Required: out_valid=0, beat_count=0, active_sel=0 the cycle after reset.
- beat_count preloaded near the top via CNT_W=4, 17 pops:
  - Required: beat_count=1.
